// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// datapath mux selects and fault codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_FAULT    = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/imm_src_decoder.sv
// Opcode -> immediate-format select; purely combinational so a pipelined core
// can reuse it in its decode stage.
module imm_src_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    unique case (op)
      OP_LW, OP_I: imm_src = IMM_I;
      OP_SW:       imm_src = IMM_S;
      OP_BEQ:      imm_src = IMM_B;
      OP_JAL:      imm_src = IMM_J;
      default:     imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core, with a mem_ready handshake,
// a per-access wait timeout and a sticky fault code.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned WAIT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       instr_retire,
  output logic [1:0] fault
);

  localparam logic [WAIT_W:0] TIMEOUT_LIM = (WAIT_W + 1)'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        fault_q, fault_d;
  logic [WAIT_W:0]   wait_inc;
  logic [1:0]        fault_code;
  logic              pc_update, branch, waiting;
  logic              ir_write_s, mem_write_s, reg_write_s, retire_s;

  imm_src_decoder u_imm_src_decoder (
    .op      (op),
    .imm_src (imm_src)
  );

  assign wait_inc = {1'b0, wait_q} + {{WAIT_W{1'b0}}, 1'b1};

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    retire_s    = 1'b0;
    waiting     = 1'b0;
    fault_code  = FAULT_NONE;

    unique case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write_s = mem_ready;
        pc_update  = mem_ready;
        waiting    = !mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        unique case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d    = S_FAULT;
            fault_code = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        if (op == OP_LW) begin
          state_d = S_MEMREAD;
        end else if (op == OP_SW) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d    = S_FAULT;
          fault_code = FAULT_ILLEGAL;
        end
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        waiting = !mem_ready;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
        waiting     = !mem_ready;
        retire_s    = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        retire_s  = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase

    // A completing access (mem_ready=1) never counts as a wait, so it always beats the timeout.
    if (waiting && (wait_inc >= TIMEOUT_LIM)) begin
      state_d    = S_FAULT;
      fault_code = FAULT_TIMEOUT;
    end
  end

  always_comb begin
    if (state_d != state_q) wait_d = '0;
    else if (waiting)       wait_d = wait_inc[WAIT_W-1:0];
    else                    wait_d = wait_q;
    fault_d = (fault_q == FAULT_NONE) ? fault_code : fault_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // Gating with rst_n keeps FETCH's mem_ready-driven strobes quiet while reset is held.
  assign pc_write     = rst_n & (pc_update | (branch & zero));
  assign ir_write     = rst_n & ir_write_s;
  assign mem_write    = rst_n & mem_write_s;
  assign reg_write    = rst_n & reg_write_s;
  assign instr_retire = rst_n & retire_s;
  assign fault        = fault_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: a phase-list model of each instruction predicts every
// output cycle by cycle; latencies and fault codes are pinned by hand values.
module tb_multicycle_controller;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_retire;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src, fault;

  multicycle_controller #(.MEM_TIMEOUT(T), .WAIT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op           (op),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .adr_src      (adr_src),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .result_src   (result_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .imm_src      (imm_src),
    .reg_write    (reg_write),
    .instr_retire (instr_retire),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                P_EXECR, P_EXECI, P_ALUWB, P_BEQ, P_JAL, P_FAULT} phase_e;

  typedef struct {
    phase_e     ph;
    logic       mr;
    logic [1:0] code;
  } entry_t;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       instr_retire;
    logic [1:0] fault;
  } outs_t;

  entry_t     seq[$];
  int         checks = 0;
  int         errors = 0;
  outs_t      exp_cur, got;
  logic       exp_valid = 1'b0;
  logic [1:0] fault_m = 2'b00;
  phase_e     cur_ph = P_FETCH;

  assign got = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, alu_op, imm_src, reg_write, instr_retire, fault};

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected outputs for one cycle, straight from the per-state control table.
  function automatic outs_t exp_outs(phase_e ph, logic mr, logic [6:0] o, logic z, logic [1:0] f);
    outs_t e;
    e = '0;
    case (o)
      SW:      e.imm_src = 2'b01;
      BQ:      e.imm_src = 2'b10;
      JL:      e.imm_src = 2'b11;
      default: e.imm_src = 2'b00;
    endcase
    e.fault = f;
    case (ph)
      P_FETCH:    begin e.alu_src_b = 2'b10; e.result_src = 2'b10; e.ir_write = mr; e.pc_write = mr; end
      P_DECODE:   begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; end
      P_MEMADR:   begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
      P_MEMREAD:  e.adr_src = 1'b1;
      P_MEMWB:    begin e.result_src = 2'b01; e.reg_write = 1'b1; e.instr_retire = 1'b1; end
      P_MEMWRITE: begin e.adr_src = 1'b1; e.mem_write = 1'b1; e.instr_retire = mr; end
      P_EXECR:    begin e.alu_src_a = 2'b10; e.alu_op = 2'b10; end
      P_EXECI:    begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_op = 2'b10; end
      P_ALUWB:    begin e.reg_write = 1'b1; e.instr_retire = 1'b1; end
      P_BEQ:      begin e.alu_src_a = 2'b10; e.alu_op = 2'b01; e.pc_write = z; e.instr_retire = 1'b1; end
      P_JAL:      begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
      default:    ;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_valid) check($sformatf("outs[%s]", cur_ph.name()), 32'(got), 32'(exp_cur));
  end

  task automatic push(input phase_e ph, input logic mr, input logic [1:0] c);
    entry_t e;
    e.ph = ph; e.mr = mr; e.code = c;
    seq.push_back(e);
  endtask

  task automatic add_fault(input logic [1:0] c);
    for (int i = 0; i < 3; i++) push(P_FAULT, 1'b1, c);
  endtask

  // w stalled cycles then completion; T consecutive stalls end in a timeout fault.
  task automatic add_wait(input phase_e ph, input int w, output bit to);
    to = (w >= T);
    if (to) begin
      for (int i = 0; i < T; i++) push(ph, 1'b0, 2'b00);
      add_fault(2'b10);
    end else begin
      for (int i = 0; i < w; i++) push(ph, 1'b0, 2'b00);
      push(ph, 1'b1, 2'b00);
    end
  endtask

  task automatic build(input logic [6:0] o, input int fw, input int mw);
    bit to;
    add_wait(P_FETCH, fw, to);
    if (!to) begin
      push(P_DECODE, 1'b1, 2'b00);
      case (o)
        LW: begin
          push(P_MEMADR, 1'b1, 2'b00);
          add_wait(P_MEMREAD, mw, to);
          if (!to) push(P_MEMWB, 1'b1, 2'b00);
        end
        SW: begin
          push(P_MEMADR, 1'b1, 2'b00);
          add_wait(P_MEMWRITE, mw, to);
        end
        RT: begin push(P_EXECR, 1'b1, 2'b00); push(P_ALUWB, 1'b1, 2'b00); end
        IT: begin push(P_EXECI, 1'b1, 2'b00); push(P_ALUWB, 1'b1, 2'b00); end
        BQ: push(P_BEQ, 1'b1, 2'b00);
        JL: begin push(P_JAL, 1'b1, 2'b00); push(P_ALUWB, 1'b1, 2'b00); end
        default: add_fault(2'b01);
      endcase
    end
  endtask

  // Starts mid-cycle with the DUT in the first queued phase; ends one step after a rising edge.
  task automatic run_seq(input logic [6:0] o, input logic z, output int first_ret, output logic pcw_at_ret);
    int n;
    entry_t e;
    n = 0;
    first_ret = -1;
    pcw_at_ret = 1'b0;
    while (seq.size() > 0) begin
      e = seq.pop_front();
      n++;
      op = o; zero = z; mem_ready = e.mr;
      if (e.ph == P_FAULT && fault_m == 2'b00) fault_m = e.code;
      cur_ph = e.ph;
      exp_cur = exp_outs(e.ph, e.mr, o, z, fault_m);
      exp_valid = 1'b1;
      @(negedge clk);
      if (instr_retire && first_ret < 0) begin
        first_ret = n;
        pcw_at_ret = pc_write;
      end
      @(posedge clk);
      #1;
    end
    exp_valid = 1'b0;
  endtask

  task automatic instr(input string name, input logic [6:0] o, input logic z, input int fw,
                       input int mw, input int exp_lat, output logic pcw);
    int fr;
    build(o, fw, mw);
    run_seq(o, z, fr, pcw);
    check({name, " latency"}, 32'(fr), 32'(exp_lat));
  endtask

  // Holds reset across a rising edge with mem_ready=1, then releases it mid-cycle.
  task automatic do_reset();
    exp_valid = 1'b0;
    rst_n = 1'b0;
    fault_m = 2'b00;
    #1;
    check("reset strobes", 32'({pc_write, ir_write, mem_write, reg_write, instr_retire}), 32'd0);
    check("reset fault", 32'(fault), 32'd0);
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    #1;
    check("reset gated fetch strobes", 32'({pc_write, ir_write}), 32'd0);
    rst_n = 1'b1;
  endtask

  logic pcw;
  int   fr;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    instr("rtype", RT, 1'b0, 0, 0, 4, pcw);
    instr("itype", IT, 1'b0, 0, 0, 4, pcw);
    instr("lw mem stall 3", LW, 1'b0, 0, 3, 8, pcw);
    instr("lw fetch stall 2", LW, 1'b0, 2, 0, 7, pcw);
    instr("beq taken", BQ, 1'b1, 0, 0, 3, pcw);
    check("beq taken pc_write", 32'(pcw), 32'd1);
    instr("beq not taken", BQ, 1'b0, 0, 0, 3, pcw);
    check("beq not taken pc_write", 32'(pcw), 32'd0);
    instr("jal", JL, 1'b0, 0, 0, 4, pcw);
    instr("sw", SW, 1'b0, 0, 0, 4, pcw);
    instr("sw mem stall 3", SW, 1'b0, 0, 3, 7, pcw);

    // Abort a store after three stalled cycles; the counter must restart from zero.
    push(P_FETCH, 1'b1, 2'b00);
    push(P_DECODE, 1'b1, 2'b00);
    push(P_MEMADR, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) push(P_MEMWRITE, 1'b0, 2'b00);
    run_seq(SW, 1'b0, fr, pcw);
    mem_ready = 1'b0;
    #1;
    check("mem_write before abort", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mem_write async drop", 32'(mem_write), 32'd0);
    do_reset();
    instr("rtype fetch stall 3 after abort", RT, 1'b0, 3, 0, 7, pcw);
    check("no fault after abort", 32'(fault), 32'd0);

    instr("sw timeout", SW, 1'b0, 0, 4, -1, pcw);
    check("timeout fault code", 32'(fault), 32'd2);
    do_reset();

    instr("fetch timeout", RT, 1'b0, 4, 0, -1, pcw);
    check("fetch timeout fault code", 32'(fault), 32'd2);
    do_reset();

    instr("illegal op", 7'b1111111, 1'b0, 0, 0, -1, pcw);
    check("illegal fault code", 32'(fault), 32'd1);
    do_reset();
    instr("rtype after fault", RT, 1'b0, 0, 0, 4, pcw);
    check("fault cleared", 32'(fault), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
